// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the execution sequencer: state encoding,
// instruction field layout, opcode/alu_op values, rstatus codes, wr_sel values.
// Also provides the instruction decode helper used by the sequencer.
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MD_WAIT = 3'd3,
    ST_WB      = 3'd4
  } state_t;

  localparam int         MD_TIMEOUT_DEF  = 40;
  localparam logic [4:0] RSTATUS_REG_DEF = 5'd30;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] CODE_ADD  = 3'd1;
  localparam logic [2:0] CODE_ADDI = 3'd2;
  localparam logic [2:0] CODE_SUB  = 3'd3;
  localparam logic [2:0] CODE_MUL  = 3'd4;
  localparam logic [2:0] CODE_DIV  = 3'd5;
  localparam logic [2:0] CODE_TMO  = 3'd6;

  localparam logic [1:0] WR_SEL_ALU     = 2'd0;
  localparam logic [1:0] WR_SEL_MD      = 2'd1;
  localparam logic [1:0] WR_SEL_RSTATUS = 2'd2;

  // Only the instruction fields the sequencer needs are kept in the IR copy.
  typedef struct packed {
    logic [4:0] opcode;   // instr[31:27]
    logic [4:0] rd;       // instr[26:22]
    logic [4:0] alu_op;   // instr[6:2]
  } ir_t;

  typedef struct packed {
    logic       writes;    // supported instruction that produces an Rd result
    logic       is_addi;
    logic       is_md;     // mul or div
    logic       is_div;
    logic       ovf_chk;   // add/addi/sub honour alu_overflow
    logic [2:0] ovf_code;
    logic [4:0] rd;
  } dec_t;

  typedef struct packed {
    logic        ir_en;
    logic        pc_en;
    logic        md_start;
    logic        md_is_div;
    logic        alu_src_imm;
    logic        rf_we;
    logic [4:0]  rf_wr_addr;
    logic [1:0]  wr_sel;
    logic [31:0] rstatus_val;
    logic        busy;
  } out_t;

  function automatic dec_t decode_ir(input ir_t ir);
    dec_t d;
    d    = '0;
    d.rd = ir.rd;
    if (ir.opcode == OP_ADDI) begin
      d.writes   = 1'b1;
      d.is_addi  = 1'b1;
      d.ovf_chk  = 1'b1;
      d.ovf_code = CODE_ADDI;
    end else if (ir.opcode == OP_RTYPE) begin
      case (ir.alu_op)
        ALU_ADD: begin
          d.writes   = 1'b1;
          d.ovf_chk  = 1'b1;
          d.ovf_code = CODE_ADD;
        end
        ALU_SUB: begin
          d.writes   = 1'b1;
          d.ovf_chk  = 1'b1;
          d.ovf_code = CODE_SUB;
        end
        ALU_AND, ALU_OR, ALU_SLL, ALU_SRA: d.writes = 1'b1;
        ALU_MUL: begin
          d.writes = 1'b1;
          d.is_md  = 1'b1;
        end
        ALU_DIV: begin
          d.writes = 1'b1;
          d.is_md  = 1'b1;
          d.is_div = 1'b1;
        end
        default: d = '0;  // unsupported alu_op behaves as NOP
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/exec_sequencer_md_wait_counter.sv
// Purpose: counts cycles spent waiting on the mult/div unit; flags terminal count.
// Latency: tc is a decode of the registered count (asserts in the MD_TIMEOUT-th wait cycle).
// Backpressure: none; clear has priority over enable.
// Ports: clock, reset (sync active-low), clear, enable, tc (count == MD_TIMEOUT-1).
module md_wait_counter #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tc = (count_q == CW'(MD_TIMEOUT - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/[MD_WAIT]/WB control FSM; drives IR/PC strobes,
//   RF write control, mult/div start and rstatus exception writes.
// Latency: 4 cycles per ALU/addi/NOP instruction; mul/div add the MD_WAIT cycles.
// Backpressure: stall holds the FSM in FETCH; md_ready (or timeout) releases MD_WAIT.
// Ports: clock, reset (sync active-low), stall, instruction, alu_overflow, md_ready,
//   md_exception in; ir_en, pc_en, md_start, md_is_div, alu_src_imm, rf_we, rf_wr_addr,
//   wr_sel, rstatus_val, busy out (all registered).
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int         MD_TIMEOUT  = MD_TIMEOUT_DEF,
  parameter logic [4:0] RSTATUS_REG = RSTATUS_REG_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        alu_overflow,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        ir_en,
  output logic        pc_en,
  output logic        md_start,
  output logic        md_is_div,
  output logic        alu_src_imm,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [1:0]  wr_sel,
  output logic [31:0] rstatus_val,
  output logic        busy
);

  state_t     state_q, state_d;
  ir_t        ir_q, ir_d;
  dec_t       dec;
  out_t       out_q, out_d;
  logic       md_clr, md_en, md_tc;
  logic       wb_exc;
  logic [2:0] wb_code;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^{instruction[21:7], instruction[1:0]};

  // State register; outputs are registered alongside so they line up with the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
    end
  end

  // IR copy is taken while in DECODE; decoding the incoming word directly in
  // that cycle lets the EXEC outputs be registered on the DECODE->EXEC edge.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_DECODE) begin
      ir_d = '{opcode: instruction[31:27], rd: instruction[26:22], alu_op: instruction[6:2]};
    end
  end

  assign dec = decode_ir(ir_d);

  assign md_clr = (state_q == ST_EXEC);
  assign md_en  = (state_q == ST_MD_WAIT);

  md_wait_counter #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_wait_counter (
    .clock (clock),
    .reset (reset),
    .clear (md_clr),
    .enable(md_en),
    .tc    (md_tc)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (!stall) state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXEC;
      ST_EXEC:    state_d = dec.is_md ? ST_MD_WAIT : ST_WB;
      ST_MD_WAIT: if (md_ready || md_tc) state_d = ST_WB;
      ST_WB:      state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Exception resolution for the WB about to be entered. From MD_WAIT, a
  // ready result takes precedence over a coincident timeout.
  always_comb begin
    wb_exc  = 1'b0;
    wb_code = '0;
    if (state_q == ST_MD_WAIT) begin
      if (md_ready) begin
        wb_exc  = md_exception;
        wb_code = dec.is_div ? CODE_DIV : CODE_MUL;
      end else begin
        wb_exc  = 1'b1;
        wb_code = CODE_TMO;
      end
    end else begin
      wb_exc  = dec.ovf_chk && alu_overflow;
      wb_code = dec.ovf_code;
    end
  end

  // Output values for the state being entered.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != ST_FETCH);
    case (state_d)
      ST_DECODE: out_d.ir_en = 1'b1;
      ST_EXEC: begin
        out_d.alu_src_imm = dec.is_addi;
        out_d.md_start    = dec.is_md;
        out_d.md_is_div   = dec.is_div;
      end
      ST_MD_WAIT: out_d.md_is_div = dec.is_div;
      ST_WB: begin
        out_d.pc_en       = 1'b1;
        // addi result is still on the ALU output during WB, so keep the imm operand selected.
        out_d.alu_src_imm = dec.is_addi;
        if (wb_exc) begin
          out_d.rf_we       = 1'b1;
          out_d.rf_wr_addr  = RSTATUS_REG;
          out_d.wr_sel      = WR_SEL_RSTATUS;
          out_d.rstatus_val = {29'd0, wb_code};
        end else if (dec.writes && (dec.rd != 5'd0)) begin
          out_d.rf_we      = 1'b1;
          out_d.rf_wr_addr = dec.rd;
          out_d.wr_sel     = dec.is_md ? WR_SEL_MD : WR_SEL_ALU;
        end
      end
      default: out_d.busy = (state_d != ST_FETCH);
    endcase
  end

  assign ir_en       = out_q.ir_en;
  assign pc_en       = out_q.pc_en;
  assign md_start    = out_q.md_start;
  assign md_is_div   = out_q.md_is_div;
  assign alu_src_imm = out_q.alu_src_imm;
  assign rf_we       = out_q.rf_we;
  assign rf_wr_addr  = out_q.rf_wr_addr;
  assign wr_sel      = out_q.wr_sel;
  assign rstatus_val = out_q.rstatus_val;
  assign busy        = out_q.busy;

endmodule
